// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: two requesters sharing one ALU,
// plus the registered response channel.
interface alu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
);
  logic            r0_valid;
  logic            r0_ready;
  logic [OPW-1:0]  r0_op;
  logic [XLEN-1:0] r0_a;
  logic [XLEN-1:0] r0_b;
  logic            r1_valid;
  logic            r1_ready;
  logic [OPW-1:0]  r1_op;
  logic [XLEN-1:0] r1_a;
  logic [XLEN-1:0] r1_b;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_id;
  logic [XLEN-1:0] resp_result;
  logic            resp_zero;
  logic            resp_err;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    output resp_ready,
    input  r0_ready, r1_ready,
    input  resp_valid, resp_id, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    input  resp_ready,
    output r0_ready, r1_ready,
    output resp_valid, resp_id, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a single registered response stage under valid/ready backpressure.
module alu_arbiter #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_SLT = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_NOR = OPW'(4'b1100);

  state_t          state_q, state_d;
  logic            last_grant_q;
  logic            id_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            err_q;

  logic            can_issue;
  logic            grant0, grant1;
  logic            ready0, ready1;
  logic            accept;
  logic [OPW-1:0]  sel_op;
  logic [XLEN-1:0] sel_a, sel_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_err;

  // Arbitration and next state. Ready is suppressed during reset so nothing
  // is accepted in a cycle whose result would be discarded.
  always_comb begin
    state_d   = state_q;
    can_issue = (state_q == IDLE) || bus.resp_ready;
    grant0    = bus.r0_valid && (!bus.r1_valid || last_grant_q);
    grant1    = bus.r1_valid && (!bus.r0_valid || !last_grant_q);
    ready0    = !reset && can_issue && grant0;
    ready1    = !reset && can_issue && grant1;
    accept    = ready0 || ready1;
    if (accept)
      state_d = HOLD;
    else if (state_q == HOLD && bus.resp_ready)
      state_d = IDLE;
  end

  always_comb begin
    sel_op = ready1 ? bus.r1_op : bus.r0_op;
    sel_a  = ready1 ? bus.r1_a  : bus.r0_a;
    sel_b  = ready1 ? bus.r1_b  : bus.r0_b;
  end

  // Shared ALU; undefined op codes resolve to a clean zero result with err.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (sel_op)
      OP_AND:  alu_res = sel_a & sel_b;
      OP_OR:   alu_res = sel_a | sel_b;
      OP_ADD:  alu_res = sel_a + sel_b;
      OP_SUB:  alu_res = sel_a - sel_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, (sel_a < sel_b)};
      OP_NOR:  alu_res = ~(sel_a | sel_b);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= ready1;
        id_q         <= ready1;
        result_q     <= alu_res;
        zero_q       <= !alu_err && (alu_res == '0);
        err_q        <= alu_err;
      end
    end
  end

  assign bus.r0_ready    = ready0;
  assign bus.r1_ready    = ready1;
  assign bus.resp_valid  = (state_q == HOLD);
  assign bus.resp_id     = id_q;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign bus.resp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  localparam int XLEN = 64;
  localparam int OPW  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

  alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Model state: whether a response is held, what it contains, who went last.
  logic            m_hold;
  logic            m_id;
  logic [XLEN-1:0] m_res;
  logic            m_zero;
  logic            m_err;
  logic            m_last;
  logic            g0, g1;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu_ref(input logic [3:0] op, input logic [XLEN-1:0] a,
                                  input logic [XLEN-1:0] b, output logic [XLEN-1:0] r,
                                  output logic z, output logic e);
    e = 1'b0;
    r = '0;
    case (op)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = (a < b) ? 64'd1 : 64'd0;
      4'd12:   r = ~(a | b);
      default: e = 1'b1;
    endcase
    z = !e && (r == 0);
  endfunction

  // One clock: inputs were applied after the previous edge; readies are
  // checked mid-cycle, response outputs just after the edge.
  task automatic tick();
    logic e0, e1, can, tv;
    logic [3:0] op;
    logic [XLEN-1:0] a, b;
    @(negedge clk);
    can = !m_hold || bus.resp_ready;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!reset && can) begin
      if (bus.r0_valid && bus.r1_valid) begin
        if (m_last) e0 = 1'b1; else e1 = 1'b1;
      end else begin
        e0 = bus.r0_valid;
        e1 = bus.r1_valid;
      end
    end
    chk("r0_ready", bus.r0_ready, e0);
    chk("r1_ready", bus.r1_ready, e1);
    g0 = bus.r0_ready;
    g1 = bus.r1_ready;
    op = e1 ? bus.r1_op : bus.r0_op;
    a  = e1 ? bus.r1_a  : bus.r0_a;
    b  = e1 ? bus.r1_b  : bus.r0_b;
    tv = m_hold;
    if (reset) begin
      m_hold = 1'b0; m_id = 1'b0; m_res = '0; m_zero = 1'b0; m_err = 1'b0; m_last = 1'b1;
    end else if (e0 || e1) begin
      alu_ref(op, a, b, m_res, m_zero, m_err);
      m_hold = 1'b1;
      m_id   = e1;
      m_last = e1;
    end else if (tv && bus.resp_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("resp_valid", bus.resp_valid, m_hold);
    chk("resp_noX", $isunknown({bus.resp_valid, bus.resp_id, bus.resp_result,
                                bus.resp_zero, bus.resp_err, bus.r0_ready, bus.r1_ready}), 0);
    if (m_hold) begin
      chk("resp_id", bus.resp_id, m_id);
      chk("resp_result", bus.resp_result, m_res);
      chk("resp_zero", bus.resp_zero, m_zero);
      chk("resp_err", bus.resp_err, m_err);
    end
  endtask

  task automatic idle_inputs();
    bus.r0_valid = 1'b0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_b = '0;
    bus.r1_valid = 1'b0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_b = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            zero;
    logic            err;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] op_pool[8];

  initial begin
    vecs[0]  = '{4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 64'hFF00, 64'h0FF0, 64'h0F00, 1'b0, 1'b0};
    vecs[4]  = '{4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[5]  = '{4'b0111, 64'd3, 64'd5, 64'd1, 1'b0, 1'b0};
    vecs[6]  = '{4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0};
    vecs[7]  = '{4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0};
    vecs[9]  = '{4'b1111, 64'd3, 64'd4, 64'd0, 1'b0, 1'b1};
    vecs[10] = '{4'b0011, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1};
    vecs[11] = '{4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b1, 1'b0};
    op_pool = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15, 4'd3};

    m_hold = 1'b0; m_id = 1'b0; m_res = '0; m_zero = 1'b0; m_err = 1'b0; m_last = 1'b1;
    g0 = 1'b0; g1 = 1'b0;
    idle_inputs();
    bus.resp_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_result", bus.resp_result, 0);
    chk("rst_zero", bus.resp_zero, 0);
    chk("rst_err", bus.resp_err, 0);
    chk("rst_id", bus.resp_id, 0);

    // Directed single ops through r0, each followed by a drain cycle.
    for (int i = 0; i < 12; i++) begin
      bus.r0_valid = 1'b1; bus.r0_op = vecs[i].op; bus.r0_a = vecs[i].a; bus.r0_b = vecs[i].b;
      tick();
      chk("vec_result", bus.resp_result, vecs[i].res);
      chk("vec_zero", bus.resp_zero, vecs[i].zero);
      chk("vec_err", bus.resp_err, vecs[i].err);
      chk("vec_id", bus.resp_id, 0);
      idle_inputs();
      tick();
      chk("vec_drain", bus.resp_valid, 0);
    end

    // Both requesters contending after reset alternate starting with r0.
    do_reset();
    bus.r0_valid = 1'b1; bus.r0_op = 4'b0110; bus.r0_a = 64'd9;    bus.r0_b = 64'd9;
    bus.r1_valid = 1'b1; bus.r1_op = 4'b0001; bus.r1_a = 64'hF0;   bus.r1_b = 64'h0F;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant0", g0, (k % 2) == 0);
      chk("rr_grant1", g1, (k % 2) == 1);
      chk("rr_id", bus.resp_id, k % 2);
      chk("rr_result", bus.resp_result, (k % 2) ? 64'hFF : 64'd0);
      chk("rr_zero", bus.resp_zero, (k % 2) == 0);
    end
    idle_inputs();
    tick();

    // Backpressure: held response stays put; new op enters on release.
    bus.r0_valid = 1'b1; bus.r0_op = 4'b0010; bus.r0_a = 64'd1; bus.r0_b = 64'd2;
    tick();
    bus.resp_ready = 1'b0;
    bus.r0_a = 64'd10; bus.r0_b = 64'd20;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ready", g0, 0);
      chk("bp_result", bus.resp_result, 64'd3);
      chk("bp_valid", bus.resp_valid, 1);
    end
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_accept", g0, 1);
    chk("bp_new", bus.resp_result, 64'd30);
    idle_inputs();
    tick();

    // Undefined op from r1.
    bus.r1_valid = 1'b1; bus.r1_op = 4'b1111; bus.r1_a = 64'hDEAD; bus.r1_b = 64'hBEEF;
    tick();
    chk("bad_err", bus.resp_err, 1);
    chk("bad_result", bus.resp_result, 0);
    chk("bad_zero", bus.resp_zero, 0);
    chk("bad_id", bus.resp_id, 1);
    idle_inputs();
    tick();

    // Reset while a response is held.
    bus.r0_valid = 1'b1; bus.r0_op = 4'b0000; bus.r0_a = 64'hF; bus.r0_b = 64'h3;
    bus.resp_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rsthold_valid", bus.resp_valid, 0);
    chk("rsthold_ready", g0, 0);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    bus.r1_valid = 1'b1; bus.r1_op = 4'b0010; bus.r1_a = 64'd1; bus.r1_b = 64'd1;
    tick();
    chk("rsthold_g0", g0, 1);
    chk("rsthold_g1", g1, 0);
    idle_inputs();
    tick();

    // Randomized traffic; a requester only changes its op once accepted.
    g0 = 1'b0; g1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.r0_valid || g0) begin
        bus.r0_valid = ($urandom_range(0, 3) != 0);
        bus.r0_op = op_pool[$urandom_range(0, 7)];
        bus.r0_a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        bus.r0_b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      end
      if (!bus.r1_valid || g1) begin
        bus.r1_valid = ($urandom_range(0, 3) != 0);
        bus.r1_op = op_pool[$urandom_range(0, 7)];
        bus.r1_a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
        bus.r1_b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
